// File: rtl/ring_arb_pkg.sv
// Shared definitions for the ring arbiter: FSM state encoding and default sizing.
package ring_arb_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational wrap-around priority search: the first request at or after the
// token position (ascending, wrapping N-1 -> 0) that is not excluded wins.
module rr_pick
  import ring_arb_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  token,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [N-1:0] cand;
  int           start;
  int           j;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path leaves it unassigned (no latch).
    cand   = req & ~excl;
    start  = 0;
    j      = 0;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (token[i]) start = i;
    end
    for (int k = 0; k < N; k++) begin
      j = (start + k) % N;
      if (!any && cand[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        index     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin ring arbiter with bounded hold time: a grant is kept while its
// requester asserts req, but is force-rotated after MAX_HOLD cycles if others wait.
module ring_arbiter
  import ring_arb_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IW       = $clog2(N),
  localparam int HW       = $clog2(MAX_HOLD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id,
  output logic [N-1:0]  token,
  output logic          timeout
);

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [N-1:0]    token_q, token_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            timeout_q, timeout_d;

  logic [N-1:0]    excl;
  logic [N-1:0]    pick_onehot;
  logic [IW-1:0]   pick_index;
  logic            pick_any;
  logic            issue;

  // The current holder is never its own successor on release or forced rotation.
  assign excl = (state_q == GRANT) ? gnt_q : '0;

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .token  (token_q),
    .excl   (excl),
    .onehot (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    token_d   = token_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    issue     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) issue = 1'b1;
      end
      GRANT: begin
        if (!req[gnt_id_q]) begin
          if (pick_any) begin
            issue = 1'b1;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end else if (pick_any) begin
          issue     = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (issue) begin
      state_d  = GRANT;
      gnt_d    = pick_onehot;
      gnt_id_d = pick_index;
      hold_d   = '0;
      token_d  = {pick_onehot[N-2:0], pick_onehot[N-1]};
    end

    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      token_q     <= N'(1);
      hold_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      token_q     <= token_d;
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign token     = token_q;
  assign timeout   = timeout_q;

endmodule
